fan_sum_collector: RTL and testbench
====================================

// Module: fan_sum_collector
// PURPOSE
// Consumer end of the carry-save forwarding adder network (FAN). Captures one FAN
// result vector (N-1 per-boundary sums plus their valid mask and the operand vec_ids).
// Serializes only the valid sums onto a ready/valid stream, one per cycle, in
// ascending boundary index. Each output is tagged with its vec_id.
// Sits between the FAN reduction stage and the output buffer / writeback stage.
// PARAMETERS
// N   32               number of FAN operands; FAN emits N-1 sums
// W   8                operand bit-width
// V   3                vec_id bit-width
// S   W+$clog2(N)      sum width, equal to the FAN output width
// IW  $clog2(N-1)      width of the boundary-index output
// PORTS
// clk         in   1           clock, rising edge
// rst         in   1           synchronous, active-high reset
// in_valid    in   1           FAN result vector present
// in_ready    out  1           collector can accept a vector this cycle
// in_sums     in   (N-1)*S     packed [N-2:0][S-1:0] FAN id_sums
// in_valids   in   N-1         FAN id_valids; bit i set = sum i ends a group
// in_vec_ids  in   N*V         packed [N-1:0][V-1:0] operand vec_ids
// out_valid   out  1           out_* carry a valid sum
// out_ready   in   1           downstream accepts
// out_sum     out  S           selected sum
// out_vec_id  out  V           vec_id of the group = captured vec_ids[i+1] for sum i
// out_idx     out  IW          boundary index i of the sum
// out_last    out  1           this is the final valid sum of the captured vector
// BEHAVIOUR
// - Two states:
//   - IDLE: pending mask is zero; in_ready=1.
//   - DRAIN: pending mask is nonzero.
// - Accept happens when in_valid && in_ready. It registers in_sums, in_vec_ids and
//   pending <= in_valids.
//   - If in_valids==0: no output is produced and the state stays IDLE.
// - Latency: a vector accepted at edge t drives out_valid=1 with its first sum in cycle t+1.
// - Selection: i = lowest set bit of pending.
//   - out_sum = sums_q[i], out_vec_id = vec_ids_q[i+1], out_idx = i.
//   - out_last = (pending with bit i cleared) == 0.
// - Handshake: out_valid && out_ready clears bit i at the edge.
//   - out_valid may not drop, and out_* may not change, while out_valid && !out_ready.
// - in_ready = IDLE || (out_valid && out_ready && out_last).
//   - Back-to-back vectors therefore stream with no bubble.
//   - A new vector may be captured on the same edge as the last handshake.
// - in_ready does not depend combinationally on in_valid.
//   - out_valid does not depend combinationally on out_ready.
// - Throughput: K set bits in in_valids produce exactly K handshakes in K cycles
//   when out_ready is held high.
// - in_* values are ignored unless an accept occurs.
// - Captured data is unaffected by later in_* changes.
// - Reset, including mid-drain: pending<=0, state IDLE.
//   - out_valid=0, out_last=0, out_sum=0, out_vec_id=0, out_idx=0, in_ready=1.
//   - Captured data is discarded; the first cycle after rst drops emits nothing.
// - Sums are passed through unmodified, S bits wide; no arithmetic is done here.
// TESTING
// 1. Groups of vec_ids 0:{0..3}, 1:{4..9}, 2:{10..31}; valids at 2, 8, 30; sums 10, 60, 400.
//    -> (2,0,10), (8,1,60), (30,2,400,last) on consecutive cycles.
// 2. Same vector, out_ready low for 3 cycles at the second output.
//    -> (8,1,60) held stable for 4 cycles; no loss and no duplicates.
// 3. Two vectors back-to-back, out_ready=1.
//    -> second vector accepted on the last-handshake edge; its first sum appears the next
//       cycle with no gap.
// 4. in_valids=0 accepted.
//    -> out_valid stays 0 and in_ready stays 1.
// 5. All 31 bits set with sums = index.
//    -> 31 outputs with idx 0..30 ascending; out_last only on idx 30.
// 6. rst asserted after the second handshake of test 1.
//    -> all outputs zero next cycle, in_ready=1; remaining sums are never emitted.

Source files
------------

// File: rtl/fan_sum_collector.sv
// Purpose: captures one FAN result vector and streams its valid per-boundary sums out, lowest index first.
// Latency: a vector accepted at edge t presents its first sum in cycle t+1; then one sum per cycle.
// Backpressure: out_* hold while out_valid && !out_ready; in_ready rises only when idle or on the last handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   vector handshake; in_ready never looks at in_valid
//   in_sums               [N-2:0][S-1:0] per-boundary sums from the FAN
//   in_valids             [N-2:0] bit i set = sum i closes a group
//   in_vec_ids            [N-1:0][V-1:0] operand vec_ids
//   out_valid / out_ready sum handshake; out_valid never looks at out_ready
//   out_sum, out_vec_id   selected sum and its group's vec_id (vec_ids[i+1])
//   out_idx, out_last     boundary index, and "final sum of this vector"
module fan_sum_collector #(
  parameter int N  = 32,
  parameter int W  = 8,
  parameter int V  = 3,
  parameter int S  = W + $clog2(N),
  parameter int IW = $clog2(N-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-2:0][S-1:0]   in_sums,
  input  logic [N-2:0]          in_valids,
  input  logic [N-1:0][V-1:0]   in_vec_ids,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [S-1:0]          out_sum,
  output logic [V-1:0]          out_vec_id,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state;
  logic [N-2:0]        pending;
  logic [N-2:0][S-1:0] sums_q;
  logic [N-1:0][V-1:0] vec_ids_q;

  logic [N-2:0]        sel_onehot;
  logic [IW-1:0]       sel_idx;
  logic [S-1:0]        sel_sum;
  logic [V-1:0]        sel_vec;
  logic [N-2:0]        pending_rest;
  logic                fire_out;
  logic                accept;

  // Operand 0 never tags a group: sum i belongs to the group ending at operand i+1.
  logic unused_vec0;
  assign unused_vec0 = ^vec_ids_q[0];

  // Lowest set bit of pending wins; scanning downward lets the lowest overwrite.
  // With pending empty everything stays zero, which gives the all-zero idle outputs.
  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    sel_sum    = '0;
    sel_vec    = '0;
    for (int i = N-2; i >= 0; i--) begin
      if (pending[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_idx       = IW'(i);
        sel_sum       = sums_q[i];
        sel_vec       = vec_ids_q[i+1];
      end
    end
  end

  assign pending_rest = pending & ~sel_onehot;

  // The state register always mirrors (pending != 0), so outputs come from flops only.
  assign out_valid  = (state == DRAIN);
  assign out_sum    = sel_sum;
  assign out_vec_id = sel_vec;
  assign out_idx    = sel_idx;
  assign out_last   = out_valid && (pending_rest == '0);

  assign fire_out = out_valid && out_ready;
  // Taking a new vector on the last handshake edge keeps back-to-back vectors bubble-free.
  assign in_ready = (state == IDLE) || (fire_out && out_last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      sums_q    <= '0;
      vec_ids_q <= '0;
    end else if (accept) begin
      pending   <= in_valids;
      sums_q    <= in_sums;
      vec_ids_q <= in_vec_ids;
      state     <= (in_valids != '0) ? DRAIN : IDLE;
    end else if (fire_out) begin
      pending   <= pending_rest;
      state     <= (pending_rest != '0) ? DRAIN : IDLE;
    end
  end

endmodule

// File: tb/tb_fan_sum_collector.sv
module tb_fan_sum_collector;
  localparam int N  = 32;
  localparam int W  = 8;
  localparam int V  = 3;
  localparam int S  = W + $clog2(N);
  localparam int IW = $clog2(N-1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N-2:0][S-1:0] in_sums;
  logic [N-2:0]        in_valids;
  logic [N-1:0][V-1:0] in_vec_ids;
  logic                out_valid;
  logic                out_ready;
  logic [S-1:0]        out_sum;
  logic [V-1:0]        out_vec_id;
  logic [IW-1:0]       out_idx;
  logic                out_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fan_sum_collector #(.N(N), .W(W), .V(V)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sums(in_sums), .in_valids(in_valids), .in_vec_ids(in_vec_ids),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_vec_id(out_vec_id), .out_idx(out_idx), .out_last(out_last)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [V-1:0]  vec;
    logic [S-1:0]  sum;
    logic          last;
  } exp_t;

  exp_t exp_q[$];

  // Reference: every set bit of the mask yields one output, ascending,
  // tagged with the vec_id of the operand just after the boundary.
  function automatic void model_push(input logic [N-2:0] m, input logic [N-2:0][S-1:0] sums,
                                     input logic [N-1:0][V-1:0] vids);
    int   last_i;
    exp_t e;
    last_i = -1;
    for (int i = 0; i < N-1; i++) if (m[i]) last_i = i;
    for (int i = 0; i < N-1; i++) begin
      if (m[i]) begin
        e.idx  = IW'(i);
        e.vec  = vids[i+1];
        e.sum  = sums[i];
        e.last = (i == last_i);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.idx  = out_idx;
    e.vec  = out_vec_id;
    e.sum  = out_sum;
    e.last = out_last;
    return e;
  endfunction

  function automatic logic [N-2:0] rand_mask();
    logic [N-2:0] m;
    m = (N-1)'($urandom()) & (N-1)'($urandom());
    if (m == '0) m[$urandom_range(N-2)] = 1'b1;
    return m;
  endfunction

  task automatic scramble();
    for (int i = 0; i < N-1; i++) in_sums[i] = S'($urandom());
    for (int i = 0; i < N; i++) in_vec_ids[i] = V'($urandom());
    in_valids = (N-1)'($urandom());
  endtask

  // Groups 0:{0..3}, 1:{4..9}, 2:{10..31}; boundaries 2, 8, 30; sums 10, 60, 400.
  task automatic load_t1();
    scramble();
    for (int i = 0; i < N; i++) in_vec_ids[i] = (i <= 3) ? V'(0) : (i <= 9) ? V'(1) : V'(2);
    in_valids = '0;
    in_valids[2] = 1'b1; in_valids[8] = 1'b1; in_valids[30] = 1'b1;
    in_sums[2] = S'(10); in_sums[8] = S'(60); in_sums[30] = S'(400);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; scramble();
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    checks++; if (out_vec_id !== '0) begin errors++; $display("FAIL reset_out_vec_id: got %h want 0", out_vec_id); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_out_idx: got %h want 0", out_idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    exp_t got;
    @(negedge clk); load_t1(); in_valid = 1'b1; out_ready = 1'b1;
    model_push(in_valids, in_sums, in_vec_ids); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      got = observed();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL basic_out[%0d]: got %h want %h", k, got, exp_q[0]); end
      checks++; if (in_ready !== (k == 2)) begin errors++; $display("FAIL basic_in_ready[%0d]: got %b want %b", k, in_ready, (k == 2)); end
      void'(exp_q.pop_front());
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    exp_t e_arr[3];
    exp_t got;
    int   rdy[6] = '{1, 0, 0, 0, 1, 1};
    int   sel[6] = '{0, 1, 1, 1, 1, 2};
    @(negedge clk); load_t1(); in_valid = 1'b1; out_ready = 1'b1;
    model_push(in_valids, in_sums, in_vec_ids);
    for (int i = 0; i < 3; i++) e_arr[i] = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); in_valid = 1'b0; scramble(); out_ready = rdy[k][0]; #1;
      got = observed();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (got !== e_arr[sel[k]]) begin errors++; $display("FAIL stall_out[%0d]: got %h want %h", k, got, e_arr[sel[k]]); end
      checks++; if (in_ready !== (k == 5)) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want %b", k, in_ready, (k == 5)); end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N-2:0] ma, mb;
    int   ka, total;
    exp_t got;
    ma = rand_mask(); mb = rand_mask();
    @(negedge clk); scramble(); in_valids = ma; in_valid = 1'b1; out_ready = 1'b1;
    model_push(in_valids, in_sums, in_vec_ids);
    ka = exp_q.size();
    total = ka + $countones(mb);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk); scramble();
      if (k == ka) begin
        in_valids = mb; in_valid = 1'b1;
        model_push(in_valids, in_sums, in_vec_ids);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      got = observed();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL b2b_out[%0d]: got %h want %h", k, got, exp_q[0]); end
      if (k == ka) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_last: got %b want 1", in_ready); end
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_empty();
    @(negedge clk); scramble(); in_valids = '0; in_valid = 1'b1; out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_accept_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b0; out_ready = 1'($urandom()); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid[%0d]: got %b want 0", k, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_in_ready[%0d]: got %b want 1", k, in_ready); end
    end
  endtask

  task automatic test_all();
    exp_t got;
    @(negedge clk); scramble(); in_valids = '1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N-1; i++) in_sums[i] = S'(i);
    model_push(in_valids, in_sums, in_vec_ids);
    for (int k = 0; k < N-1; k++) begin
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      got = observed();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL all_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_idx !== IW'(k) || out_sum !== S'(k)) begin errors++; $display("FAIL all_idx_sum[%0d]: got idx %0d sum %0d want %0d", k, out_idx, out_sum, k); end
      checks++; if (out_last !== (k == N-2)) begin errors++; $display("FAIL all_last[%0d]: got %b want %b", k, out_last, (k == N-2)); end
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL all_out[%0d]: got %h want %h", k, got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL all_done_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); load_t1(); in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) begin @(negedge clk); in_valid = 1'b0; scramble(); end
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL midrst_valid_last: got %b/%b want 0/0", out_valid, out_last); end
    checks++; if (out_sum !== '0 || out_vec_id !== '0 || out_idx !== '0) begin errors++; $display("FAIL midrst_data: got sum %h vec %h idx %h want 0", out_sum, out_vec_id, out_idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_silent[%0d]: got %b want 0", k, out_valid); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int   acc = 0;
    int   cyc = 0;
    logic exp_rdy;
    exp_t got;
    exp_q.delete();
    while ((acc < 25 || exp_q.size() > 0) && cyc < 4000) begin
      @(negedge clk); cyc++;
      scramble();
      case ($urandom_range(3))
        0: in_valids = '0;
        1: begin in_valids = '0; in_valids[$urandom_range(N-2)] = 1'b1; end
        2: in_valids = (N-1)'($urandom());
        default: in_valids = rand_mask();
      endcase
      in_valid  = (acc < 25) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      #1;
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, out_valid, (exp_q.size() > 0)); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready, exp_rdy); end
      if (out_valid && exp_q.size() > 0) begin
        got = observed();
        checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL rand_out[%0d]: got %h want %h", cyc, got, exp_q[0]); end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        model_push(in_valids, in_sums, in_vec_ids);
        acc++;
      end
    end
    in_valid = 1'b0;
    checks++; if (acc < 25 || exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout: accepted %0d pending %0d want 25/0", acc, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_empty();
    test_all();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
